// File: rtl/vx_sched_csr_counters_if.sv
// CSR read port between the CSR unit (master) and the scheduler counter block (slave).
// rd_valid has no ready: every request is accepted, and rsp_valid/rsp_data follow exactly one cycle later.
interface vx_sched_csr_counters_if #(
  parameter int WID_W = 2,
  parameter int XLEN  = 32
);
  logic             rd_valid;
  logic [1:0]       rd_sel;
  logic [WID_W-1:0] rd_wid;
  logic             rd_hi;
  logic             rsp_valid;
  logic [XLEN-1:0]  rsp_data;

  modport master (
    output rd_valid, rd_sel, rd_wid, rd_hi,
    input  rsp_valid, rsp_data
  );

  modport slave (
    input  rd_valid, rd_sel, rd_wid, rd_hi,
    output rsp_valid, rsp_data
  );
endinterface

// File: rtl/vx_sched_csr_counters.sv
// Per-core scheduler CSR state: cycle/instret counters, per-warp instret, warp and thread masks,
// with a registered read port whose hi half comes from a snapshot latched by the matching lo read.
module vx_sched_csr_counters #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int CTR_BITS    = 44,
  parameter int XLEN        = 32,
  parameter int CNT_BITS    = 3,
  localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             freeze,
  input  logic                             wctl_valid,
  input  logic [WID_W-1:0]                 wctl_wid,
  input  logic                             wctl_active,
  input  logic [NUM_THREADS-1:0]           wctl_tmask,
  input  logic                             commit_valid,
  input  logic [WID_W-1:0]                 commit_wid,
  input  logic [CNT_BITS-1:0]              commit_cnt,
  vx_sched_csr_counters_if.slave           csr,
  output logic [CTR_BITS-1:0]              cycles,
  output logic [CTR_BITS-1:0]              instret,
  output logic [NUM_WARPS-1:0]             active_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks
);

  localparam bit SPLIT = (CTR_BITS > XLEN);
  localparam int HI_W  = SPLIT ? (CTR_BITS - XLEN) : 1;
  localparam int EXT_W = XLEN + HI_W;

  logic [CTR_BITS-1:0]    r_cycles;
  logic [CTR_BITS-1:0]    r_instret;
  logic [CTR_BITS-1:0]    r_winstret [NUM_WARPS];
  logic [NUM_WARPS-1:0]   r_active;
  logic [NUM_THREADS-1:0] r_tmask [NUM_WARPS];
  logic [HI_W-1:0]        r_snap;
  logic                   r_rsp_valid;
  logic [XLEN-1:0]        r_rsp_data;

  logic [CTR_BITS-1:0]    w_cnt_ext;
  logic [CTR_BITS-1:0]    w_ctr;
  logic [EXT_W-1:0]       w_ctr_ext;
  logic [XLEN-1:0]        w_rd_data;
  logic                   w_snap_we;

  assign w_cnt_ext = CTR_BITS'(commit_cnt);

  // freeze stalls the counters only; warp control keeps working so the scheduler can still park warps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycles  <= '0;
      r_instret <= '0;
      r_active  <= NUM_WARPS'(1);
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_winstret[w] <= '0;
        r_tmask[w]    <= (w == 0) ? NUM_THREADS'(1) : '0;
      end
    end else begin
      if (!freeze) begin
        r_cycles <= r_cycles + CTR_BITS'(1);
        if (commit_valid) begin
          r_instret              <= r_instret + w_cnt_ext;
          r_winstret[commit_wid] <= r_winstret[commit_wid] + w_cnt_ext;
        end
      end
      if (wctl_valid) begin
        r_active[wctl_wid] <= wctl_active;
        r_tmask[wctl_wid]  <= wctl_active ? wctl_tmask : '0;
      end
    end
  end

  always_comb begin
    w_ctr = '0;
    case (csr.rd_sel)
      2'd0:    w_ctr = r_cycles;
      2'd1:    w_ctr = r_instret;
      2'd2:    w_ctr = r_winstret[csr.rd_wid];
      default: w_ctr = '0;
    endcase
    w_ctr_ext = EXT_W'(w_ctr);
    w_rd_data = '0;
    if (csr.rd_sel == 2'd3) begin
      if (!csr.rd_hi) w_rd_data = XLEN'({r_active[csr.rd_wid], r_tmask[csr.rd_wid]});
    end else if (csr.rd_hi) begin
      if (SPLIT) w_rd_data = XLEN'(r_snap);
    end else begin
      w_rd_data = w_ctr_ext[XLEN-1:0];
    end
  end

  // One snapshot shared by all counters: a hi read returns whatever the most recent counter lo read latched.
  assign w_snap_we = SPLIT && csr.rd_valid && (csr.rd_sel != 2'd3) && !csr.rd_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_snap      <= '0;
    end else begin
      r_rsp_valid <= csr.rd_valid;
      if (csr.rd_valid) r_rsp_data <= w_rd_data;
      if (w_snap_we) r_snap <= w_ctr_ext[XLEN +: HI_W];
    end
  end

  assign csr.rsp_valid = r_rsp_valid;
  assign csr.rsp_data  = r_rsp_data;
  assign cycles        = r_cycles;
  assign instret       = r_instret;
  assign active_warps  = r_active;

  always_comb begin
    thread_masks = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      thread_masks[w*NUM_THREADS +: NUM_THREADS] = r_tmask[w];
    end
  end

endmodule

// File: tb/tb_vx_sched_csr_counters.sv
// Directed bench for vx_sched_csr_counters: reset, counting, freeze, warp control and hi/lo reads.
module tb_vx_sched_csr_counters;

  logic        clk;
  logic        reset_n;
  logic        freeze;
  logic        wctl_valid;
  logic [1:0]  wctl_wid;
  logic        wctl_active;
  logic [3:0]  wctl_tmask;
  logic        commit_valid;
  logic [1:0]  commit_wid;
  logic [2:0]  commit_cnt;
  logic [43:0] cycles;
  logic [43:0] instret;
  logic [3:0]  active_warps;
  logic [15:0] thread_masks;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  vx_sched_csr_counters_if #(.WID_W(2), .XLEN(32)) csr_if ();

  vx_sched_csr_counters dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .freeze       (freeze),
    .wctl_valid   (wctl_valid),
    .wctl_wid     (wctl_wid),
    .wctl_active  (wctl_active),
    .wctl_tmask   (wctl_tmask),
    .commit_valid (commit_valid),
    .commit_wid   (commit_wid),
    .commit_cnt   (commit_cnt),
    .csr          (csr_if.slave),
    .cycles       (cycles),
    .instret      (instret),
    .active_warps (active_warps),
    .thread_masks (thread_masks)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset_n         = 1'b0;
    freeze          = 1'b0;
    wctl_valid      = 1'b0;
    wctl_wid        = '0;
    wctl_active     = 1'b0;
    wctl_tmask      = '0;
    commit_valid    = 1'b0;
    commit_wid      = '0;
    commit_cnt      = '0;
    csr_if.rd_valid = 1'b0;
    csr_if.rd_sel   = '0;
    csr_if.rd_wid   = '0;
    csr_if.rd_hi    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // driver: issue one read at the current negedge; the response is stable at the next negedge
  task automatic do_read(input logic [1:0] sel, input logic [1:0] wid, input logic hi);
    csr_if.rd_valid = 1'b1;
    csr_if.rd_sel   = sel;
    csr_if.rd_wid   = wid;
    csr_if.rd_hi    = hi;
    @(negedge clk);
    csr_if.rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (cycles !== 44'd0) begin n_err++; $display("FAIL reset_cycles got=%h exp=%h", cycles, 44'd0); end
    n_cmp++; if (instret !== 44'd0) begin n_err++; $display("FAIL reset_instret got=%h exp=%h", instret, 44'd0); end
    n_cmp++; if (active_warps !== 4'b0001) begin n_err++; $display("FAIL reset_active got=%b exp=0001", active_warps); end
    n_cmp++; if (thread_masks !== 16'h0001) begin n_err++; $display("FAIL reset_tmask got=%h exp=0001", thread_masks); end
    n_cmp++; if (csr_if.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", csr_if.rsp_valid); end
    n_cmp++; if (csr_if.rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", csr_if.rsp_data); end
  endtask

  task automatic test_reset_midrun();
    commit_valid = 1'b1; commit_wid = 2'd0; commit_cnt = 3'd4;
    @(negedge clk);
    commit_valid = 1'b0;
    repeat (56) @(negedge clk);
    n_cmp++; if (cycles !== 44'd57) begin n_err++; $display("FAIL midrun_cycles got=%0d exp=57", cycles); end
    csr_if.rd_valid = 1'b1; csr_if.rd_sel = 2'd0; csr_if.rd_wid = 2'd0; csr_if.rd_hi = 1'b0;
    @(posedge clk);
    #1;
    csr_if.rd_valid = 1'b0;
    n_cmp++; if (csr_if.rsp_valid !== 1'b1) begin n_err++; $display("FAIL midrun_rsp_valid got=%b exp=1", csr_if.rsp_valid); end
    n_cmp++; if (csr_if.rsp_data !== 32'd57) begin n_err++; $display("FAIL midrun_rsp_data got=%0d exp=57", csr_if.rsp_data); end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (cycles !== 44'd0) begin n_err++; $display("FAIL async_cycles got=%h exp=0", cycles); end
    n_cmp++; if (instret !== 44'd0) begin n_err++; $display("FAIL async_instret got=%h exp=0", instret); end
    n_cmp++; if (active_warps !== 4'b0001) begin n_err++; $display("FAIL async_active got=%b exp=0001", active_warps); end
    n_cmp++; if (csr_if.rsp_valid !== 1'b0) begin n_err++; $display("FAIL async_rsp_valid got=%b exp=0", csr_if.rsp_valid); end
    do_reset();
  endtask

  task automatic test_commit();
    commit_valid = 1'b1; commit_wid = 2'd2; commit_cnt = 3'd3;
    @(negedge clk);
    commit_wid = 2'd1; commit_cnt = 3'd5;
    @(negedge clk);
    commit_wid = 2'd1; commit_cnt = 3'd0;
    @(negedge clk);
    commit_valid = 1'b0;
    n_cmp++; if (instret !== 44'd8) begin n_err++; $display("FAIL commit_instret got=%0d exp=8", instret); end
    do_read(2'd2, 2'd2, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'd3) begin n_err++; $display("FAIL commit_w2 got=%0d exp=3", csr_if.rsp_data); end
    do_read(2'd2, 2'd1, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'd5) begin n_err++; $display("FAIL commit_w1 got=%0d exp=5", csr_if.rsp_data); end
    do_read(2'd2, 2'd0, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'd0) begin n_err++; $display("FAIL commit_w0 got=%0d exp=0", csr_if.rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sels [4];
    logic [1:0]  wids [4];
    logic [31:0] exps [4];
    logic [31:0] exp_v;
    sels[0] = 2'd2; wids[0] = 2'd2; exps[0] = 32'd3;
    sels[1] = 2'd2; wids[1] = 2'd1; exps[1] = 32'd5;
    sels[2] = 2'd1; wids[2] = 2'd0; exps[2] = 32'd8;
    sels[3] = 2'd3; wids[3] = 2'd0; exps[3] = 32'h11;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        csr_if.rd_valid = 1'b1; csr_if.rd_sel = sels[i]; csr_if.rd_wid = wids[i]; csr_if.rd_hi = 1'b0;
        exp_q.push_back(exps[i]);
      end else begin
        csr_if.rd_valid = 1'b0;
      end
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        n_cmp++; if (csr_if.rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i-1, csr_if.rsp_valid); end
        n_cmp++; if (csr_if.rsp_data !== exp_v) begin n_err++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i-1, csr_if.rsp_data, exp_v); end
      end
      @(negedge clk);
    end
    n_cmp++; if (csr_if.rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", csr_if.rsp_valid); end
  endtask

  task automatic test_freeze();
    do_reset();
    freeze = 1'b1;
    commit_valid = 1'b1; commit_wid = 2'd0; commit_cnt = 3'd7;
    wctl_wid = 2'd2; wctl_active = 1'b1; wctl_tmask = 4'hA;
    for (int i = 0; i < 10; i++) begin
      wctl_valid = (i == 3);
      @(negedge clk);
    end
    wctl_valid = 1'b0;
    commit_valid = 1'b0;
    n_cmp++; if (cycles !== 44'd0) begin n_err++; $display("FAIL freeze_cycles got=%0d exp=0", cycles); end
    n_cmp++; if (instret !== 44'd0) begin n_err++; $display("FAIL freeze_instret got=%0d exp=0", instret); end
    n_cmp++; if (active_warps !== 4'b0101) begin n_err++; $display("FAIL freeze_active got=%b exp=0101", active_warps); end
    n_cmp++; if (thread_masks !== 16'h0A01) begin n_err++; $display("FAIL freeze_tmask got=%h exp=0a01", thread_masks); end
    freeze = 1'b0;
    @(negedge clk);
    n_cmp++; if (cycles !== 44'd1) begin n_err++; $display("FAIL unfreeze_cycles got=%0d exp=1", cycles); end
    do_read(2'd2, 2'd0, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'd0) begin n_err++; $display("FAIL freeze_w0 got=%0d exp=0", csr_if.rsp_data); end
  endtask

  task automatic test_same_warp();
    commit_valid = 1'b1; commit_wid = 2'd3; commit_cnt = 3'd2;
    wctl_valid = 1'b1; wctl_wid = 2'd3; wctl_active = 1'b1; wctl_tmask = 4'h5;
    @(negedge clk);
    commit_valid = 1'b0; wctl_valid = 1'b0;
    n_cmp++; if (instret !== 44'd2) begin n_err++; $display("FAIL same_instret got=%0d exp=2", instret); end
    n_cmp++; if (active_warps !== 4'b1101) begin n_err++; $display("FAIL same_active got=%b exp=1101", active_warps); end
    n_cmp++; if (thread_masks !== 16'h5A01) begin n_err++; $display("FAIL same_tmask got=%h exp=5a01", thread_masks); end
    do_read(2'd2, 2'd3, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'd2) begin n_err++; $display("FAIL same_w3 got=%0d exp=2", csr_if.rsp_data); end
    do_read(2'd3, 2'd3, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'h15) begin n_err++; $display("FAIL same_mask3 got=%h exp=15", csr_if.rsp_data); end
  endtask

  task automatic test_wctl();
    wctl_valid = 1'b1; wctl_wid = 2'd3; wctl_active = 1'b1; wctl_tmask = 4'hF;
    @(negedge clk);
    n_cmp++; if (thread_masks[15:12] !== 4'hF) begin n_err++; $display("FAIL wctl_on_tmask got=%h exp=f", thread_masks[15:12]); end
    wctl_active = 1'b0;
    @(negedge clk);
    wctl_valid = 1'b0;
    n_cmp++; if (active_warps !== 4'b0101) begin n_err++; $display("FAIL wctl_off_active got=%b exp=0101", active_warps); end
    n_cmp++; if (thread_masks !== 16'h0A01) begin n_err++; $display("FAIL wctl_off_tmask got=%h exp=0a01", thread_masks); end
    do_read(2'd3, 2'd3, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'd0) begin n_err++; $display("FAIL wctl_mask3 got=%h exp=0", csr_if.rsp_data); end
    do_read(2'd3, 2'd2, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'h1A) begin n_err++; $display("FAIL wctl_mask2 got=%h exp=1a", csr_if.rsp_data); end
    do_read(2'd3, 2'd2, 1'b1);
    n_cmp++; if (csr_if.rsp_data !== 32'd0) begin n_err++; $display("FAIL wctl_mask2_hi got=%h exp=0", csr_if.rsp_data); end
  endtask

  task automatic test_wrap();
    dut.r_cycles = 44'hFFF_FFFF_FFFF;
    @(negedge clk);
    n_cmp++; if (cycles !== 44'd0) begin n_err++; $display("FAIL wrap_cycles got=%h exp=0", cycles); end
    dut.r_instret = 44'hFFF_FFFF_FFFE;
    commit_valid = 1'b1; commit_wid = 2'd0; commit_cnt = 3'd7;
    @(negedge clk);
    commit_valid = 1'b0;
    n_cmp++; if (instret !== 44'd5) begin n_err++; $display("FAIL wrap_instret got=%h exp=5", instret); end
  endtask

  task automatic test_hilo();
    dut.r_cycles = 44'h0_0001_FFFF_FFFF;
    do_read(2'd0, 2'd0, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL hilo_lo got=%h exp=ffffffff", csr_if.rsp_data); end
    repeat (3) @(negedge clk);
    do_read(2'd0, 2'd0, 1'b1);
    n_cmp++; if (csr_if.rsp_data !== 32'd1) begin n_err++; $display("FAIL hilo_hi got=%h exp=1", csr_if.rsp_data); end
    do_read(2'd3, 2'd0, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'h11) begin n_err++; $display("FAIL hilo_mask0 got=%h exp=11", csr_if.rsp_data); end
    do_read(2'd0, 2'd0, 1'b1);
    n_cmp++; if (csr_if.rsp_data !== 32'd1) begin n_err++; $display("FAIL hilo_hi_kept got=%h exp=1", csr_if.rsp_data); end
    do_read(2'd1, 2'd0, 1'b0);
    n_cmp++; if (csr_if.rsp_data !== 32'd5) begin n_err++; $display("FAIL hilo_instret_lo got=%h exp=5", csr_if.rsp_data); end
    do_read(2'd1, 2'd0, 1'b1);
    n_cmp++; if (csr_if.rsp_data !== 32'd0) begin n_err++; $display("FAIL hilo_instret_hi got=%h exp=0", csr_if.rsp_data); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_reset_midrun();
    test_commit();
    test_back_to_back();
    test_freeze();
    test_same_warp();
    test_wctl();
    test_wrap();
    test_hilo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
